raster_rx: RTL

Receiving end of the pixel raster stream: accepts pixels over a valid/ready handshake with start-of-frame and end-of-line markers, recovers the (x, y) coordinate of each beat, and issues one frame-buffer write per pixel with a linear address. Sits between the video/maze-cell producer and the frame-buffer RAM write port. Detects framing errors and resynchronises on the next start-of-frame.

---
 rtl/raster_pkg.sv | 27 ++
 rtl/raster_err_counter.sv | 22 ++
 rtl/raster_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// raster_pkg: shared types and constants for the raster stream receiver.
//   state_e    : receiver sync state (SYNC waits for start-of-frame, ACTIVE tracks x/y)
//   err_code_e : framing error classification reported on err_code
//   ERR_W      : width of err_code
//   cw()       : $clog2 clamped to a minimum of 1 bit, so WIDTH/HEIGHT of 1 still
//                give legal (non-zero-width) vectors.
package raster_pkg;

  localparam int ERR_W = 2;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE        = 2'd0,
    ERR_EARLY_EOL   = 2'd1,
    ERR_MISSING_EOL = 2'd2,
    ERR_EARLY_SOF   = 2'd3
  } err_code_e;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/raster_err_counter.sv
// raster_err_counter: 16-bit saturating event counter.
//   clock   : system clock
//   resetn  : asynchronous active-low reset, clears the count
//   en_i    : count one event this cycle
//   count_o : current count, sticks at 16'hFFFF
module raster_err_counter (
  input  logic        clock,
  input  logic        resetn,
  input  logic        en_i,
  output logic [15:0] count_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                         cnt_q <= '0;
    else if (en_i && cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/raster_rx.sv
// raster_rx: receiving end of the pixel raster stream. Recovers (x, y) of each
// accepted beat, issues one registered frame-buffer write per pixel at linear
// address y*WIDTH+x, flags framing errors and resyncs on the next start-of-frame.
//   clock, resetn            : rising-edge clock, async active-low reset
//   s_valid/s_ready          : input handshake; s_data pixel, s_sof pixel (0,0), s_eol last of line
//   wr_ready                 : frame-buffer port can take a write (stalls acceptance only)
//   wr_en/wr_addr/wr_data    : write strobe, linear address, pixel value (1-cycle latency)
//   x, y                     : coordinate of the pixel currently on wr_*
//   frame_done               : pulses with the write of the last pixel of a frame
//   err/err_code             : error pulse; code held until the next error
//   err_count                : saturating error count, only with RASTER_RX_ERRCNT_EN
//                              defined (otherwise tied to 0)
module raster_rx
  import raster_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DATA_W = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_sof,
  input  logic                          s_eol,
  input  logic                          wr_ready,
  output logic                          wr_en,
  output logic [cw(WIDTH*HEIGHT)-1:0]   wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [cw(WIDTH)-1:0]          x,
  output logic [cw(HEIGHT)-1:0]         y,
  output logic                          frame_done,
  output logic                          err,
  output logic [ERR_W-1:0]              err_code,
  output logic [15:0]                   err_count
);

  localparam int XW = cw(WIDTH);
  localparam int YW = cw(HEIGHT);
  localparam int AW = cw(WIDTH*HEIGHT);

  state_e            state_q;
  logic [XW-1:0]     cx_q, px;
  logic [YW-1:0]     cy_q, py;
  logic [AW-1:0]     addr_q, pa;
  logic              wr_en_q, fd_q, err_q;
  logic [AW-1:0]     wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  err_code_e         err_code_q, code_d;
  logic              accept, take, early_sof, eol_err, last_col, last_row;
  logic              err_d, wr_d;

  assign s_ready = (state_q == SYNC) || wr_ready;

  always_comb begin
    accept    = s_valid && s_ready;
    // In SYNC only a start-of-frame beat takes part; everything else is dropped silently.
    take      = accept && (state_q == ACTIVE || s_sof);
    early_sof = (state_q == ACTIVE) && s_sof && (cx_q != '0 || cy_q != '0);
    // A sof beat always restarts at (0,0), whatever the tracked position was.
    px        = s_sof ? '0 : cx_q;
    py        = s_sof ? '0 : cy_q;
    pa        = s_sof ? '0 : addr_q;
    last_col  = (px == XW'(WIDTH-1));
    last_row  = (py == YW'(HEIGHT-1));
    // EARLY_SOF wins: the beat is still written as (0,0) and EOL is not checked.
    eol_err   = !early_sof && (s_eol != last_col);
    code_d    = early_sof ? ERR_EARLY_SOF : (s_eol ? ERR_EARLY_EOL : ERR_MISSING_EOL);
    err_d     = take && (early_sof || eol_err);
    wr_d      = take && !eol_err;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= SYNC;
      cx_q       <= '0;
      cy_q       <= '0;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      fd_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      wr_en_q <= wr_d;
      fd_q    <= wr_d && last_col && last_row;
      err_q   <= err_d;
      if (err_d) err_code_q <= code_d;
      if (wr_d) begin
        wr_addr_q <= pa;
        wr_data_q <= s_data;
        x_q       <= px;
        y_q       <= py;
      end
      if (take) begin
        if (eol_err) begin
          state_q <= SYNC;
        end else begin
          state_q <= (last_col && last_row) ? SYNC : ACTIVE;
          cx_q    <= last_col ? '0 : px + XW'(1);
          cy_q    <= last_col ? (last_row ? '0 : py + YW'(1)) : py;
          // Linear address advances by one per written pixel, no multiply needed.
          addr_q  <= pa + AW'(1);
        end
      end
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign x          = x_q;
  assign y          = y_q;
  assign frame_done = fd_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

`ifdef RASTER_RX_ERRCNT_EN
  // Enabled from err_d so the count steps in the same cycle err is seen.
  raster_err_counter u_err_cnt (
    .clock   (clock),
    .resetn  (resetn),
    .en_i    (err_d),
    .count_o (err_count)
  );
`else
  assign err_count = '0;
`endif

endmodule
